// File: rtl/adc_uart_pkg.sv
// ---------------------------------------------------------------------------
// adc_uart_pkg
// Shared definitions for the ADC capture / UART packet path:
//   - state_e        : capture and drain state encoding
//   - HEADER_DEFAULT : first byte of every packet
//   - PKT_*          : packet byte-order constants (header, count, samples)
//   - is_drain()     : true for the states that present a byte to the UART
//   - pkt_len()      : total packet length in bytes for a given sample count
// ---------------------------------------------------------------------------
package adc_uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      HDR     = 3'd2,
      CNT_HI  = 3'd3,
      CNT_LO  = 3'd4,
      SMP_HI  = 3'd5,
      SMP_LO  = 3'd6,
      DONE    = 3'd7
   } state_e;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   // Packet layout: one header byte, count MSB then LSB, then each sample
   // MSB first, LSB second.
   localparam int unsigned PKT_HDR_BYTES = 32'd1;
   localparam int unsigned PKT_CNT_BYTES = 32'd2;
   localparam int unsigned PKT_SMP_BYTES = 32'd2;

   function automatic logic is_drain(input state_e s);
      return (s inside {HDR, CNT_HI, CNT_LO, SMP_HI, SMP_LO});
   endfunction

   function automatic int unsigned pkt_len(input int unsigned n_smp);
      return PKT_HDR_BYTES + PKT_CNT_BYTES + (PKT_SMP_BYTES * n_smp);
   endfunction

endpackage

// File: rtl/sample_ram.sv
// ---------------------------------------------------------------------------
// sample_ram
// Single-clock simple dual-port RAM, DEPTH x DATA_W, registered read
// (read data appears one cycle after the address). Read-during-write to the
// same address returns the old contents.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, one cycle after raddr
// ---------------------------------------------------------------------------
module sample_ram #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      rdata <= mem_r[raddr];
   end

endmodule

// File: rtl/adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// adc_capture_buffer
// Stores ADC samples while acquire is high, then streams a packet
// {HEADER, count[15:8], count[7:0], {smp[hi], smp[lo]} x count} to a UART
// transmitter over a valid/ready handshake.
//   clk            : system clock
//   rst            : synchronous active-high reset
//   acquire        : capture window (level)
//   sample_valid   : sample_data strobe
//   sample_data    : ADC sample, SAMPLE_W bits
//   tx_data        : byte to the transmitter
//   tx_valid       : tx_data valid
//   tx_ready       : transmitter accepts when tx_valid is also high
//   busy           : high in every state except IDLE
//   missed_trigger : one-cycle pulse for an ignored acquire rising edge
// ---------------------------------------------------------------------------
module adc_capture_buffer
   import adc_uart_pkg::*;
#(
   parameter int         SAMPLE_W = 12,
   parameter int         DEPTH    = 256,
   parameter int         ADDR_W   = 8,
   parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                acquire,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic                missed_trigger
);

   localparam logic [ADDR_W-1:0] WR_ZERO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] WR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

   state_e              state_r;
   state_e              state_nxt_s;
   logic                acquire_q_r;
   logic                rise_s;
   logic                start_s;
   logic                capture_wr_s;
   logic                accept_s;
   logic                smp_load_s;
   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [ADDR_W:0]     rd_ptr_r;
   logic [ADDR_W:0]     count_r;
   logic [SAMPLE_W-1:0] sample_r;
   logic                ram_we_s;
   logic [ADDR_W-1:0]   ram_waddr_s;
   logic [SAMPLE_W-1:0] ram_rdata_s;
   logic [7:0]          tx_data_nxt_s;
   logic                tx_valid_nxt_s;
   logic                busy_nxt_s;
   logic [7:0]          tx_data_r;
   logic                tx_valid_r;
   logic                busy_r;
   logic                missed_r;

   // Upper byte of a sample, zero-extended to 16 bits first.
   function automatic logic [7:0] smp_hi(input logic [SAMPLE_W-1:0] s);
      return 8'(s >> 8);
   endfunction

   assign rise_s       = acquire & ~acquire_q_r;
   assign start_s      = (state_r == IDLE) & rise_s;
   assign capture_wr_s = (state_r == CAPTURE) & acquire & sample_valid;
   assign accept_s     = tx_valid_r & tx_ready;
   assign ram_we_s     = capture_wr_s | (start_s & sample_valid);
   assign ram_waddr_s  = (state_r == CAPTURE) ? wr_ptr_r : WR_ZERO;

   // rd_ptr already points at the following sample once SMP_HI is entered, so
   // the RAM has read it by the time SMP_LO is accepted; sample_r latches the
   // RAM output on every entry into SMP_HI and holds it through any stall.
   assign smp_load_s   = (state_nxt_s == SMP_HI) & (state_r != SMP_HI);

   sample_ram #(
      .DATA_W (SAMPLE_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .waddr (ram_waddr_s),
      .wdata (sample_data),
      .raddr (rd_ptr_r[ADDR_W-1:0]),
      .rdata (ram_rdata_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (rise_s) state_nxt_s = CAPTURE;
            else        state_nxt_s = IDLE;
         end
         CAPTURE: begin
            if (!acquire)                                  state_nxt_s = HDR;
            else if (capture_wr_s && (count_r == CNT_LAST)) state_nxt_s = HDR;
            else                                           state_nxt_s = CAPTURE;
         end
         HDR: begin
            if (accept_s) state_nxt_s = CNT_HI;
            else          state_nxt_s = HDR;
         end
         CNT_HI: begin
            if (accept_s) state_nxt_s = CNT_LO;
            else          state_nxt_s = CNT_HI;
         end
         CNT_LO: begin
            if (!accept_s)               state_nxt_s = CNT_LO;
            else if (count_r == CNT_ZERO) state_nxt_s = DONE;
            else                         state_nxt_s = SMP_HI;
         end
         SMP_HI: begin
            if (accept_s) state_nxt_s = SMP_LO;
            else          state_nxt_s = SMP_HI;
         end
         SMP_LO: begin
            if (!accept_s)              state_nxt_s = SMP_LO;
            else if (rd_ptr_r == count_r) state_nxt_s = DONE;
            else                        state_nxt_s = SMP_HI;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode from the next state so the registered outputs line up
   // with the state they describe.
   always_comb begin
      tx_valid_nxt_s = is_drain(state_nxt_s);
      busy_nxt_s     = (state_nxt_s != IDLE);
      tx_data_nxt_s  = 8'h00;
      case (state_nxt_s)
         HDR:    tx_data_nxt_s = HEADER;
         CNT_HI: tx_data_nxt_s = 8'(count_r >> 8);
         CNT_LO: tx_data_nxt_s = count_r[7:0];
         SMP_HI: begin
            if (state_r == SMP_HI) tx_data_nxt_s = smp_hi(sample_r);
            else                   tx_data_nxt_s = smp_hi(ram_rdata_s);
         end
         SMP_LO:  tx_data_nxt_s = sample_r[7:0];
         default: tx_data_nxt_s = 8'h00;
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         missed_r   <= 1'b0;
      end else begin
         tx_data_r  <= tx_data_nxt_s;
         tx_valid_r <= tx_valid_nxt_s;
         busy_r     <= busy_nxt_s;
         missed_r   <= rise_s & (state_r != IDLE);
      end
   end

   // Edge detector, write/read pointers, sample count and held sample
   always_ff @(posedge clk) begin
      if (rst) begin
         acquire_q_r <= 1'b0;
         wr_ptr_r    <= WR_ZERO;
         rd_ptr_r    <= CNT_ZERO;
         count_r     <= CNT_ZERO;
         sample_r    <= {SAMPLE_W{1'b0}};
      end else begin
         acquire_q_r <= acquire;
         if (start_s) begin
            // A sample coincident with the opening edge lands at address 0.
            wr_ptr_r <= sample_valid ? WR_ONE : WR_ZERO;
            count_r  <= sample_valid ? CNT_ONE : CNT_ZERO;
            rd_ptr_r <= CNT_ZERO;
         end else if (capture_wr_s) begin
            wr_ptr_r <= wr_ptr_r + WR_ONE;
            count_r  <= count_r + CNT_ONE;
         end else if (smp_load_s) begin
            sample_r <= ram_rdata_s;
            rd_ptr_r <= rd_ptr_r + CNT_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end
   end

   assign tx_data        = tx_data_r;
   assign tx_valid       = tx_valid_r;
   assign busy           = busy_r;
   assign missed_trigger = missed_r;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_buffer
// Self-checking bench: expected packet bytes go into a queue when a capture
// window is driven; a monitor pops and compares every accepted byte and
// checks that tx_valid/tx_data hold during stalls.
// ---------------------------------------------------------------------------
module tb_adc_capture_buffer;
   import adc_uart_pkg::*;

   logic        clk;
   logic        rst;
   logic        acquire;
   logic        sample_valid;
   logic [11:0] sample_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        missed_trigger;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          rx_count = 0;
   bit          bp_en = 1'b0;
   logic [7:0]  exp_q[$];
   logic [11:0] sd[300];
   bit          sv[300];
   logic        stall_q = 1'b0;
   logic [7:0]  held_q = 8'h00;
   logic [7:0]  exp_byte;

   typedef struct {
      logic [11:0] smp;
      logic [7:0]  exp_hi;
      logic [7:0]  exp_lo;
   } vec_t;

   vec_t        vecs[5];
   logic [7:0]  t1_bytes[9];

   adc_capture_buffer #(
      .SAMPLE_W (12),
      .DEPTH    (256),
      .ADDR_W   (8),
      .HEADER   (8'hA5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .acquire        (acquire),
      .sample_valid   (sample_valid),
      .sample_data    (sample_data),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .missed_trigger (missed_trigger)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // tx_ready: always 1, or random when backpressure is enabled
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pop on each accepted byte, hold check on stalls
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_q) begin
            check("hold_valid", tx_valid, 1'b1);
            check("hold_data", tx_data, held_q);
         end
         if (tx_valid && tx_ready) begin
            rx_count++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h expected no byte", tx_data);
            end else begin
               exp_byte = exp_q.pop_front();
               check("tx_byte", tx_data, exp_byte);
            end
         end
         stall_q = tx_valid && !tx_ready;
         held_q  = tx_data;
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic clear_stim();
      for (int i = 0; i < 300; i++) begin
         sv[i] = 1'b0;
         sd[i] = 12'h000;
      end
   endtask

   // Drives one acquire window of n cycles; optionally pushes the model packet.
   task automatic run_window(input int n, input bit use_model, output int cnt);
      logic [11:0] kept[$];
      rx_count = 0;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (sv[i] && cnt < 256) begin
            kept.push_back(sd[i]);
            cnt++;
         end
      end
      if (use_model) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'(cnt >> 8));
         exp_q.push_back(8'(cnt & 255));
         foreach (kept[k]) begin
            exp_q.push_back({4'h0, kept[k][11:8]});
            exp_q.push_back(kept[k][7:0]);
         end
      end
      for (int i = 0; i < n; i++) begin
         acquire      = 1'b1;
         sample_valid = sv[i];
         sample_data  = sd[i];
         step();
      end
      acquire      = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 12'h000;
   endtask

   task automatic wait_drain(input int budget, input int cnt);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < budget) begin
         step();
         t++;
      end
      check("queue_empty", exp_q.size(), 0);
      check("busy_idle", busy, 1'b0);
      check("pkt_len", rx_count, pkt_len(cnt));
   endtask

   task automatic check_hdr_latency();
      check("hdr_not_early", tx_valid, 1'b0);
      step();
      check("hdr_latency_valid", tx_valid, 1'b1);
      check("hdr_latency_data", tx_data, 8'hA5);
   endtask

   initial begin
      int cnt;
      int t;
      rst          = 1'b1;
      acquire      = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 12'h000;
      vecs[0] = '{12'h000, 8'h00, 8'h00};
      vecs[1] = '{12'hFFF, 8'h0F, 8'hFF};
      vecs[2] = '{12'h800, 8'h08, 8'h00};
      vecs[3] = '{12'h0FF, 8'h00, 8'hFF};
      vecs[4] = '{12'h100, 8'h01, 8'h00};
      t1_bytes = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h23, 8'h00, 8'hAB, 8'h0F, 8'hFF};

      // Reset state
      repeat (3) step();
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_missed", missed_trigger, 1'b0);
      rst = 1'b0;
      step();

      // Three samples, fixed expected bytes, header latency
      clear_stim();
      sd[0] = 12'h123; sd[1] = 12'h0AB; sd[2] = 12'hFFF;
      sv[0] = 1'b1;    sv[1] = 1'b1;    sv[2] = 1'b1;
      foreach (t1_bytes[k]) exp_q.push_back(t1_bytes[k]);
      run_window(3, 1'b0, cnt);
      check_hdr_latency();
      wait_drain(200, cnt);

      // Single-sample vectors, sample coincident with the opening edge
      for (int v = 0; v < 5; v++) begin
         clear_stim();
         sd[0] = vecs[v].smp;
         sv[0] = 1'b1;
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h01);
         exp_q.push_back(vecs[v].exp_hi);
         exp_q.push_back(vecs[v].exp_lo);
         run_window(2, 1'b0, cnt);
         wait_drain(200, cnt);
      end

      // Ten samples with gaps, without then with random backpressure
      clear_stim();
      for (int i = 0; i < 12; i++) begin
         sv[i] = (i % 6) != 5;
         sd[i] = 12'($urandom_range(0, 4095));
      end
      for (int pass = 0; pass < 2; pass++) begin
         bp_en = (pass == 1);
         run_window(12, 1'b1, cnt);
         wait_drain(500, cnt);
      end
      bp_en = 1'b0;
      step();

      // Overflow: 300 cycles of samples, only the first 256 kept
      clear_stim();
      for (int i = 0; i < 300; i++) begin
         sv[i] = 1'b1;
         sd[i] = 12'($urandom_range(0, 4095));
      end
      run_window(300, 1'b1, cnt);
      wait_drain(3000, cnt);

      // Empty window
      clear_stim();
      run_window(5, 1'b1, cnt);
      check_hdr_latency();
      wait_drain(200, cnt);

      // Retrigger during drain, acquire held high past DONE
      clear_stim();
      sd[0] = 12'h5A5; sd[1] = 12'h3C3; sd[2] = 12'h00F;
      sv[0] = 1'b1;    sv[1] = 1'b1;    sv[2] = 1'b1;
      run_window(3, 1'b1, cnt);
      repeat (3) step();
      check("busy_drain", busy, 1'b1);
      acquire = 1'b1;
      step();
      check("missed_pulse", missed_trigger, 1'b1);
      step();
      check("missed_one_cycle", missed_trigger, 1'b0);
      wait_drain(200, cnt);
      for (int i = 0; i < 10; i++) begin
         step();
         check("no_restart", busy, 1'b0);
      end
      acquire = 1'b0;
      repeat (5) step();
      check("no_restart_after", busy, 1'b0);

      // Reset after four bytes of a drain, then a fresh packet
      clear_stim();
      sd[0] = 12'h234; sd[1] = 12'h9AB; sd[2] = 12'h777;
      sv[0] = 1'b1;    sv[1] = 1'b1;    sv[2] = 1'b1;
      run_window(3, 1'b1, cnt);
      t = 0;
      while (rx_count < 4 && t < 50) begin
         step();
         t++;
      end
      check("rx4_reached", rx_count >= 4, 1'b1);
      rst = 1'b1;
      step();
      check("midrst_tx_valid", tx_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_tx_data", tx_data, 8'h00);
      exp_q.delete();
      rst = 1'b0;
      step();
      clear_stim();
      sd[0] = 12'hC01; sd[1] = 12'h0DE;
      sv[0] = 1'b1;    sv[1] = 1'b1;
      run_window(2, 1'b1, cnt);
      check_hdr_latency();
      wait_drain(200, cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Downstream consumer of the UART-triggered acquire window.
- While acquire is high, stores ADC samples into an on-chip buffer. When the window closes, streams a framed byte packet (header, count, samples) to the UART transmitter over a valid/ready handshake.
- Sits between the ADC sample interface plus acquire generator on one side and the UART TX byte serializer on the other.

Parameters:
- SAMPLE_W, 12, ADC sample width in bits; legal range 9..16.
- DEPTH, 256, maximum samples per capture window.
- ADDR_W, 8, buffer address width; must satisfy 2**ADDR_W == DEPTH.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- acquire  in  1  capture window from the trigger stage; level-sensitive, registered upstream.
- sample_valid  in  1  one-cycle strobe: sample_data is valid this cycle.
- sample_data  in  SAMPLE_W  ADC sample.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte this cycle when tx_valid is also high.
- busy  out  1  high in every state except IDLE.
- missed_trigger  out  1  one-cycle pulse when an acquire rising edge is ignored.

Behaviour:
- Reset:
  - state=IDLE; wr_ptr, rd_ptr and count are 0.
  - tx_valid=0, tx_data=0, busy=0, missed_trigger=0.
  - The acquire edge detector register clears to 0.
  - Reset mid-capture or mid-drain abandons the packet; no partial byte is completed.
- Edge detection: rise = acquire & ~acquire_q, where acquire_q is the registered copy of acquire.
- States and transitions:
  - IDLE -> CAPTURE on rise. wr_ptr=0, count=0.
  - In the rise cycle itself, a coincident sample_valid is written to address 0 and count becomes 1.
  - CAPTURE: each cycle with acquire=1 and sample_valid=1 writes sample_data at wr_ptr, then increments wr_ptr and count.
  - CAPTURE ends when acquire is sampled 0, or the write that brings count to DEPTH completes. Either way go to HDR.
  - Samples arriving with acquire=0 are never written.
  - After a DEPTH-full exit, further samples are dropped even while acquire stays high.
  - count is ADDR_W+1 bits wide, so DEPTH=256 is representable.
- Drain sequence: HDR -> CNT_HI -> CNT_LO -> then SMP_HI/SMP_LO pairs -> DONE.
  - HDR sends HEADER.
  - CNT_HI sends the 16-bit zero-extended count[15:8]; CNT_LO sends count[7:0].
  - SMP_HI sends zero-extended sample[SAMPLE_W-1:8]; SMP_LO sends sample[7:0].
  - SMP_HI/SMP_LO repeat for rd_ptr = 0..count-1.
  - If count==0, go from CNT_LO directly to DONE.
- Handshake:
  - Each drain state presents its byte with tx_valid=1.
  - tx_data and tx_valid stay stable until the cycle where tx_valid & tx_ready; the state advances on that cycle.
  - A byte is never dropped or duplicated. Back-to-back acceptance gives one byte per cycle, with no bubbles required, though bubbles are allowed.
- RAM read:
  - The buffer RAM has synchronous read with 1-cycle latency. The address for the next sample is issued one cycle before SMP_HI is entered (prefetch during CNT_LO or SMP_LO), and the read data is held in a sample register.
  - A tx_ready stall must not corrupt the held sample.
- DONE: tx_valid=0; return to IDLE next cycle.
- Retriggering: a rise seen in any state other than IDLE is ignored and pulses missed_trigger for one cycle. A capture never starts from the same acquire high level after DONE.
- Latency: the first header byte appears with tx_valid=1 exactly 1 cycle after the cycle in which acquire is sampled 0 (or the DEPTH-th write).

Decomposition:
- Shared package adc_uart_pkg holds:
  - the state enum: IDLE, CAPTURE, HDR, CNT_HI, CNT_LO, SMP_HI, SMP_LO, DONE;
  - the HEADER default;
  - the packet byte-order constants.
- One sub-module, sample_ram: single-clock simple dual-port RAM, DEPTH x SAMPLE_W, 1-cycle synchronous read, write-first not required.

Test Plan:
- Capture 3 samples: raise acquire with sample_valid on 3 cycles carrying 0x123, 0x0AB, 0xFFF, then drop acquire; tx_ready=1 throughout -> bytes A5,00,03,01,23,00,AB,0F,FF; then busy=0.
- Random tx_ready backpressure (~50%) on a 10-sample capture -> identical byte stream to the tx_ready=1 run; tx_data holds stable on every stalled cycle.
- Overflow: acquire high for 300 cycles with sample_valid every cycle -> count=256 (bytes 01,00 after header); samples 257..300 not stored; last pair equals sample 256.
- Empty window: acquire high for 5 cycles, sample_valid=0 -> packet A5,00,00 only.
- Retrigger: pulse acquire again during the drain of the first packet -> missed_trigger high for 1 cycle; the first packet completes unchanged; no second packet.
- Reset asserted mid-drain after 4 bytes -> next cycle tx_valid=0, busy=0; a fresh acquire then produces a complete new packet starting with A5.
